m1_muldiv: RTL and testbench

M1_MULDIV -- requirements
Module: m1_muldiv

---
 rtl/m1_muldiv_pkg.sv | 20 ++
 rtl/m1_muldiv_step.sv | 44 ++++
 rtl/m1_muldiv.sv | 160 ++++++++++++++++
 tb/tb_m1_muldiv.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/m1_muldiv_pkg.sv
// Shared op codes, FSM encoding and helpers for the m1_muldiv iterative multiply/divide unit.
package m1_muldiv_pkg;

  localparam logic [1:0] MDU_OP_MUL_LO = 2'd0;
  localparam logic [1:0] MDU_OP_MUL_HI = 2'd1;
  localparam logic [1:0] MDU_OP_DIV    = 2'd2;
  localparam logic [1:0] MDU_OP_REM    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // DIV and REM share op[1]; MUL_LO/MUL_HI differ only in which product half is returned.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/m1_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// Divider path exists only when M1_MULDIV_DIV_EN is defined.
module m1_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] opnd,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH:0] sum;
`ifdef M1_MULDIV_DIV_EN
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
`else
  logic unused_is_div;
  assign unused_is_div = is_div;
`endif

  always_comb begin
    // Multiply: {hi,lo} holds {partial product, remaining multiplier bits}.
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    hi_nxt = sum[WIDTH:1];
    lo_nxt = {sum[0], lo[WIDTH-1:1]};
`ifdef M1_MULDIV_DIV_EN
    // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        hi_nxt = diff[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/m1_muldiv.sv
// Iterative multiply/divide unit with an alternating-bit req/ack handshake, fixed WIDTH+2 latency.
// Define M1_MULDIV_DIV_EN to build the divider; otherwise DIV/REM complete in two edges with 0.
module m1_muldiv
  import m1_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             sys_clock_i,
  input  logic             sys_reset_n_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       op_i,
  input  logic             signed_i,
  input  logic             req_i,
  output logic             ack_o,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
`ifdef M1_MULDIV_DIV_EN
  logic [WIDTH-1:0]   quot_fix, rem_fix;
`else
  logic unused_div;
  assign unused_div = neg_rem_q ^ div_zero_q;
`endif

  m1_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (op_is_div(op_q)),
    .opnd   (opnd_q),
    .hi     (hi_q),
    .lo     (lo_q),
    .hi_nxt (step_hi),
    .lo_nxt (step_lo)
  );

  always_comb begin
    state_d    = state_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    result_d   = result_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    ack_d      = ack_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;

    mag_a    = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    mag_b    = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
    prod     = {hi_q, lo_q};
    prod_fix = neg_res_q ? -prod : prod;
`ifdef M1_MULDIV_DIV_EN
    // Divide by zero leaves the dividend in hi, so only the quotient needs forcing.
    quot_fix = div_zero_q ? {WIDTH{1'b1}} : (neg_res_q ? -lo_q : lo_q);
    rem_fix  = neg_rem_q ? -hi_q : hi_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_i != ack_q) begin
          op_d       = op_i;
          neg_res_d  = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          neg_rem_d  = signed_i & a_i[WIDTH-1];
          div_zero_d = (b_i == '0);
          cnt_d      = '0;
          hi_d       = '0;
          if (op_is_div(op_i)) begin
`ifdef M1_MULDIV_DIV_EN
            lo_d    = mag_a;
            opnd_d  = mag_b;
            state_d = S_BUSY;
`else
            lo_d    = '0;
            opnd_d  = '0;
            state_d = S_FIX;
`endif
          end else begin
            lo_d    = mag_b;
            opnd_d  = mag_a;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) state_d = S_FIX;
      end
      S_FIX: begin
        case (op_q)
          MDU_OP_MUL_LO: result_d = prod_fix[WIDTH-1:0];
          MDU_OP_MUL_HI: result_d = prod_fix[2*WIDTH-1:WIDTH];
`ifdef M1_MULDIV_DIV_EN
          MDU_OP_DIV:    result_d = quot_fix;
          default:       result_d = rem_fix;
`else
          default:       result_d = '0;
`endif
        endcase
        ack_d   = ~ack_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
    if (!sys_reset_n_i) begin
      state_q    <= S_IDLE;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      result_q   <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      result_q   <= result_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
    end
  end

  // Handshake: a request is pending whenever req_i differs from ack_o; it is sampled only in IDLE.
  assign ack_o    = ack_q;
  assign result_o = result_q;
  assign busy_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_m1_muldiv.sv
// Scoreboard bench for m1_muldiv (WIDTH=32): directed vectors feed an expected queue, a monitor checks each ack.
module tb_m1_muldiv;

  localparam int W = 32;
  localparam logic [1:0] OP_LO  = 2'd0;
  localparam logic [1:0] OP_HI  = 2'd1;
  localparam logic [1:0] OP_DIV = 2'd2;
  localparam logic [1:0] OP_REM = 2'd3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a_i, b_i;
  logic [1:0]   op_i;
  logic         signed_i;
  logic         req_i;
  logic         ack_o;
  logic [W-1:0] result_o;
  logic         busy_o;

  logic [W-1:0] exp_q[$];
  int           start_q[$];
  int           lat_q[$];

  int           cyc = 0;
  int           n_cmp = 0;
  int           n_fail = 0;
  logic         prev_ack = 1'b0;
  logic [W-1:0] prev_res = '0;

  logic [W-1:0] m_e;
  int           m_s, m_l, m_lat;
  logic         m_busy;

  always #5 clk = ~clk;

  m1_muldiv #(.WIDTH(W)) dut (
    .sys_clock_i   (clk),
    .sys_reset_n_i (rst_n),
    .a_i           (a_i),
    .b_i           (b_i),
    .op_i          (op_i),
    .signed_i      (signed_i),
    .req_i         (req_i),
    .ack_o         (ack_o),
    .result_o      (result_o),
    .busy_o        (busy_o)
  );

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic clear_queues();
    exp_q.delete();
    start_q.delete();
    lat_q.delete();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: %0d ops still pending after %0d cycles, required 0", exp_q.size(), t);
      clear_queues();
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                       input logic sgn, input logic [W-1:0] e_en, input logic [W-1:0] e_dis);
    logic [W-1:0] e;
    int           l;
    wait_idle();
`ifdef M1_MULDIV_DIV_EN
    e = e_en;
    l = W + 2;
`else
    e = e_dis;
    l = (op >= OP_DIV) ? 2 : W + 2;
`endif
    @(negedge clk);
    a_i      = a;
    b_i      = b;
    op_i     = op;
    signed_i = sgn;
    req_i    = ~req_i;
    exp_q.push_back(e);
    start_q.push_back(cyc + 1);
    lat_q.push_back(l);
    @(negedge clk);
    a_i      = $urandom;
    b_i      = $urandom;
    op_i     = 2'($urandom_range(0, 3));
    signed_i = 1'($urandom_range(0, 1));
    if (l > 10) begin
      repeat (3) @(negedge clk);
      req_i = ~req_i;
      repeat (3) @(negedge clk);
      req_i = ~req_i;
    end
  endtask

  // Monitor: every cycle, an ack toggle pops one expectation; otherwise result_o must hold.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        prev_ack = ack_o;
        prev_res = result_o;
      end else begin
        if (ack_o !== prev_ack) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL ack_unexpected: ack_o toggled to %0b with no pending op, required no toggle", ack_o);
          end else begin
            m_e = exp_q.pop_front();
            m_s = start_q.pop_front();
            m_l = lat_q.pop_front();
            if (result_o !== m_e) begin
              n_fail++;
              $display("FAIL result: got %h, required %h", result_o, m_e);
            end
            m_lat = cyc - m_s + 1;
            n_cmp++;
            if (m_lat != m_l) begin
              n_fail++;
              $display("FAIL latency: ack on edge %0d, required edge %0d", m_lat, m_l);
            end
          end
        end else begin
          n_cmp++;
          if (result_o !== prev_res) begin
            n_fail++;
            $display("FAIL result_hold: result_o changed to %h without ack, required %h", result_o, prev_res);
          end
        end
        m_busy = (start_q.size() > 0) && (cyc >= start_q[0]);
        n_cmp++;
        if (busy_o !== m_busy) begin
          n_fail++;
          $display("FAIL busy: got %0b, required %0b at cycle %0d", busy_o, m_busy, cyc);
        end
        prev_ack = ack_o;
        prev_res = result_o;
      end
    end
  end

  initial begin
    int s;
    rst_n    = 1'b1;
    req_i    = 1'b0;
    a_i      = '0;
    b_i      = '0;
    op_i     = OP_LO;
    signed_i = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ack", W'(ack_o), '0);
    check("reset_busy", W'(busy_o), '0);
    check("reset_result", result_o, '0);
    rst_n = 1'b1;

    // Multiply vectors.
    do_op(32'd7,        32'd6,        OP_LO, 1'b0, 32'd42,       32'd42);
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, OP_HI, 1'b0, 32'hFFFFFFFE, 32'hFFFFFFFE);
    do_op(32'hFFFFFFFF, 32'd1,        OP_HI, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op(32'hFFFFFFFD, 32'd5,        OP_LO, 1'b1, 32'hFFFFFFF1, 32'hFFFFFFF1);
    do_op(32'hFFFFFFFD, 32'd5,        OP_HI, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op(32'h12345678, 32'h10,       OP_LO, 1'b0, 32'h23456780, 32'h23456780);
    do_op(32'h80000000, 32'd4,        OP_HI, 1'b0, 32'd2,        32'd2);
    do_op(32'h80000000, 32'h80000000, OP_HI, 1'b1, 32'h40000000, 32'h40000000);

    // Divide vectors: second expected column applies when the divider is not built.
    do_op(32'hFFFFFFF9, 32'd2,        OP_DIV, 1'b1, 32'hFFFFFFFD, 32'd0);
    do_op(32'hFFFFFFF9, 32'd2,        OP_REM, 1'b1, 32'hFFFFFFFF, 32'd0);
    do_op(32'd100,      32'd7,        OP_DIV, 1'b0, 32'd14,       32'd0);
    do_op(32'd100,      32'd7,        OP_REM, 1'b0, 32'd2,        32'd0);
    do_op(32'd7,        32'hFFFFFFFE, OP_DIV, 1'b1, 32'hFFFFFFFD, 32'd0);
    do_op(32'd7,        32'hFFFFFFFE, OP_REM, 1'b1, 32'd1,        32'd0);
    do_op(32'hFFFFFFF9, 32'd2,        OP_DIV, 1'b0, 32'h7FFFFFFC, 32'd0);
    do_op(32'hFFFFFFF9, 32'd2,        OP_REM, 1'b0, 32'd1,        32'd0);
    do_op(32'd5,        32'd0,        OP_DIV, 1'b0, 32'hFFFFFFFF, 32'd0);
    do_op(32'd5,        32'd0,        OP_REM, 1'b0, 32'd5,        32'd0);
    do_op(32'hFFFFFFFB, 32'd0,        OP_DIV, 1'b1, 32'hFFFFFFFF, 32'd0);
    do_op(32'hFFFFFFFB, 32'd0,        OP_REM, 1'b1, 32'hFFFFFFFB, 32'd0);
    do_op(32'h80000000, 32'hFFFFFFFF, OP_DIV, 1'b1, 32'h80000000, 32'd0);
    do_op(32'h80000000, 32'hFFFFFFFF, OP_REM, 1'b1, 32'd0,        32'd0);
    do_op(32'd9,        32'd3,        OP_DIV, 1'b0, 32'd3,        32'd0);
    do_op(32'h1234,     32'd2,        OP_LO,  1'b0, 32'h2468,     32'h2468);

    // Reset after edge 10 of a multiply: outputs clear at once, the op is abandoned.
    wait_idle();
    @(negedge clk);
    a_i      = 32'd100;
    b_i      = 32'd200;
    op_i     = OP_LO;
    signed_i = 1'b0;
    req_i    = ~req_i;
    s        = cyc + 1;
    exp_q.push_back(32'd20000);
    start_q.push_back(s);
    lat_q.push_back(W + 2);
    while (cyc < s + 9) @(negedge clk);
    rst_n = 1'b0;
    clear_queues();
    #1;
    check("midop_reset_ack", W'(ack_o), '0);
    check("midop_reset_busy", W'(busy_o), '0);
    check("midop_reset_result", result_o, '0);
    req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'd3, 32'd3, OP_LO, 1'b0, 32'd9, 32'd9);

    // Reset released with req_i=1 starts an operation on the first edge.
    wait_idle();
    @(negedge clk);
    rst_n    = 1'b0;
    req_i    = 1'b1;
    a_i      = 32'd3;
    b_i      = 32'd5;
    op_i     = OP_LO;
    signed_i = 1'b0;
    clear_queues();
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'd15);
    start_q.push_back(cyc + 1);
    lat_q.push_back(W + 2);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
